jtroadf_objbuf: RTL

Double-banked object line buffer that sits directly downstream of the Road Fighter object scan/draw stage. It accepts 4-bit pixel writes from the drawer for the line being built while it plays back the other bank to the colour mixer at the pixel clock. Each location is erased after playback, and banks swap on every `hinit`. A first-writer-wins read-modify-write pipeline gives earlier table entries priority over later ones.

---
 rtl/jtroadf_objbuf.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jtroadf_objbuf.sv
// Road Fighter object line buffer: two 256x4 banks, one drawn while the
// other plays back and is erased behind the beam.
module jtroadf_objbuf #(
  parameter logic [7:0] HOFFSET = 8'd0,
  parameter logic [3:0] CLRVAL  = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       hinit,
  input  logic       LHBL,
  input  logic [8:0] hdump,
  input  logic       flip,
  input  logic [7:0] wr_x,
  input  logic [3:0] wr_pxl,
  input  logic       wr_en,
  output logic       init_busy,
  output logic [3:0] pxl
);

  typedef enum logic { INIT, RUN } state_t;

  state_t     st;
  logic [7:0] cnt;
  logic       wbank;

  logic [3:0] mem0 [256];
  logic [3:0] mem1 [256];

  logic       s0_v, s0_bank;
  logic [7:0] s0_x;
  logic [3:0] s0_pxl;
  logic       s1_v, s1_bank;
  logic [7:0] s1_x;
  logic [3:0] s1_pxl;
  logic       s2_v, s2_bank, s2_occ;
  logic [7:0] s2_x;
  logic [3:0] s2_pxl;

  logic       rd_v, rd_bank;
  logic [7:0] rd_addr;

  logic       run;
  logic [3:0] s1_rd;
  logic [3:0] rd_data;
  logic       s2_commit;
  logic       fwd;
  logic [7:0] pb_addr;
  logic       hdump_unused;

  assign run       = (st == RUN);
  assign s1_rd     = s1_bank ? mem1[s1_x] : mem0[s1_x];
  assign rd_data   = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  assign s2_commit = s2_v & ~s2_occ;
  assign pb_addr   = (hdump[7:0] ^ {8{flip}}) + HOFFSET;
  assign hdump_unused = hdump[8];

  // S2 is about to fill this spot, so S1 must not see it as free
  assign fwd = s2_commit & (s2_bank == s1_bank)
             & (s2_x == s1_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= INIT;
      cnt       <= 8'd0;
      init_busy <= 1'b1;
      wbank     <= 1'b0;
      s0_v      <= 1'b0;
      s0_bank   <= 1'b0;
      s0_x      <= 8'd0;
      s0_pxl    <= CLRVAL;
      s1_v      <= 1'b0;
      s1_bank   <= 1'b0;
      s1_x      <= 8'd0;
      s1_pxl    <= CLRVAL;
      s2_v      <= 1'b0;
      s2_bank   <= 1'b0;
      s2_x      <= 8'd0;
      s2_pxl    <= CLRVAL;
      s2_occ    <= 1'b0;
      rd_v      <= 1'b0;
      rd_bank   <= 1'b0;
      rd_addr   <= 8'd0;
      pxl       <= CLRVAL;
    end else begin
      if (hinit) wbank <= ~wbank;
      s1_v    <= s0_v;
      s1_bank <= s0_bank;
      s1_x    <= s0_x;
      s1_pxl  <= s0_pxl;
      s2_v    <= s1_v;
      s2_bank <= s1_bank;
      s2_x    <= s1_x;
      s2_pxl  <= s1_pxl;
      s2_occ  <= (s1_rd != CLRVAL) | fwd;
      s0_x    <= wr_x;
      s0_pxl  <= wr_pxl;
      s0_bank <= wbank;
      case (st)
        INIT: begin
          s0_v <= 1'b0;
          rd_v <= 1'b0;
          pxl  <= CLRVAL;
          cnt  <= cnt + 8'd1;
          if (cnt == 8'd255) begin
            st        <= RUN;
            init_busy <= 1'b0;
          end
        end
        default: begin
          s0_v <= wr_en & (wr_pxl != CLRVAL);
          rd_v <= pxl_cen & LHBL;
          if (pxl_cen & LHBL) begin
            rd_addr <= pb_addr;
            rd_bank <= hinit ? wbank : ~wbank;
          end
          if (pxl_cen & ~LHBL) pxl <= CLRVAL;
          else if (rd_v)       pxl <= rd_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      mem0[cnt] <= CLRVAL;
      mem1[cnt] <= CLRVAL;
    end else begin
      if (rd_v) begin
        if (rd_bank) mem1[rd_addr] <= CLRVAL;
        else         mem0[rd_addr] <= CLRVAL;
      end
      if (s2_commit) begin
        if (s2_bank) mem1[s2_x] <= s2_pxl;
        else         mem0[s2_x] <= s2_pxl;
      end
    end
  end

endmodule
